// File: rtl/if_prefetch_unit_if.sv
// Bundle of the fetch unit's redirect, imem request/response and decode handshake signals.
// The if_misalign signal exists only when IF_MISALIGN_CHECK_EN is defined.
interface if_prefetch_unit_if #(
    parameter int INSTRUCTION_WIDTH = 32,
    parameter int PC_WIDTH          = 32
);
    logic                         PCSel;
    logic [PC_WIDTH-1:0]          from_alu;
    logic                         imem_req_valid;
    logic                         imem_req_ready;
    logic [PC_WIDTH-1:0]          imem_req_addr;
    logic                         imem_rsp_valid;
    logic [INSTRUCTION_WIDTH-1:0] imem_rsp_data;
    logic                         inst_valid;
    logic                         inst_ready;
    logic [INSTRUCTION_WIDTH-1:0] inst;
    logic [PC_WIDTH-1:0]          pc_out;
    logic [PC_WIDTH-1:0]          pc_plus_4;
`ifdef IF_MISALIGN_CHECK_EN
    logic                         if_misalign;

    modport master (
        input  PCSel, from_alu, imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
        output imem_req_valid, imem_req_addr, inst_valid, inst, pc_out, pc_plus_4, if_misalign
    );
    modport slave (
        output PCSel, from_alu, imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
        input  imem_req_valid, imem_req_addr, inst_valid, inst, pc_out, pc_plus_4, if_misalign
    );
`else
    modport master (
        input  PCSel, from_alu, imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
        output imem_req_valid, imem_req_addr, inst_valid, inst, pc_out, pc_plus_4
    );
    modport slave (
        output PCSel, from_alu, imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
        input  imem_req_valid, imem_req_addr, inst_valid, inst, pc_out, pc_plus_4
    );
`endif
endinterface

// File: rtl/if_prefetch_unit.sv
// Instruction-fetch stage: credit-limited in-order imem requests, prefetch queue, redirect flush.
// Optional IF_MISALIGN_CHECK_EN adds a sticky if_misalign flag that blocks fetch on unaligned redirects.
module if_prefetch_unit #(
    parameter int                INSTRUCTION_WIDTH = 32,
    parameter int                PC_WIDTH          = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC        = '0,
    parameter int                FIFO_DEPTH        = 4,
    parameter int                MAX_OUTSTANDING   = 4
) (
    input  logic             clk,
    input  logic             reset,
    if_prefetch_unit_if.master bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int OW = $clog2(MAX_OUTSTANDING) + 1;

    logic [PC_WIDTH-1:0]          fetch_pc;
    logic [PC_WIDTH-1:0]          head_pc;
    logic [PC_WIDTH-1:0]          redirect_pc;
    logic [INSTRUCTION_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]                rd_ptr;
    logic [PW-1:0]                wr_ptr;
    logic [CW-1:0]                count;
    logic [OW-1:0]                inflight;
    logic [OW-1:0]                drop;
    logic                         misalign;
    logic                         credit_ok;
    logic                         req_valid;
    logic                         req_fire;
    logic                         rsp_take;
    logic                         push;
    logic                         pop;
    logic                         head_valid;

    // Credit counts queued entries plus responses still to be kept, so a kept
    // response always finds a free slot.
    assign credit_ok = (32'(count) + 32'(inflight) - 32'(drop) < 32'(FIFO_DEPTH)) &&
                       (32'(inflight) < 32'(MAX_OUTSTANDING));
    assign req_valid = !reset && !bus.PCSel && credit_ok && !misalign;
    assign req_fire  = req_valid && bus.imem_req_ready;

    // Responses with nothing outstanding (e.g. stragglers from before a reset) are ignored.
    assign rsp_take   = bus.imem_rsp_valid && (inflight != '0);
    assign push       = rsp_take && (drop == '0);
    assign head_valid = !reset && (count != '0);
    assign pop        = head_valid && bus.inst_ready;

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = fetch_pc;
    assign bus.inst_valid     = head_valid;
    assign bus.inst           = mem[rd_ptr];
    assign bus.pc_out         = head_pc;
    assign bus.pc_plus_4      = head_pc + PC_WIDTH'(4);

`ifdef IF_MISALIGN_CHECK_EN
    assign redirect_pc     = bus.from_alu;
    assign bus.if_misalign = misalign;

    always_ff @(posedge clk) begin
        if (reset)
            misalign <= 1'b0;
        else if (bus.PCSel)
            misalign <= |bus.from_alu[1:0];
    end
`else
    assign redirect_pc = bus.from_alu & ~PC_WIDTH'(3);
    assign misalign    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            head_pc  <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            inflight <= '0;
            drop     <= '0;
        end else if (bus.PCSel) begin
            // Everything still outstanding after this cycle belongs to the old path.
            fetch_pc <= redirect_pc;
            head_pc  <= redirect_pc;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            inflight <= inflight - OW'(rsp_take);
            drop     <= inflight - OW'(rsp_take);
        end else begin
            if (req_fire)
                fetch_pc <= fetch_pc + PC_WIDTH'(4);
            if (pop) begin
                head_pc <= head_pc + PC_WIDTH'(4);
                rd_ptr  <= rd_ptr + PW'(1);
            end
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (rsp_take && (drop != '0))
                drop <= drop - OW'(1);
            inflight <= inflight + OW'(req_fire) - OW'(rsp_take);
            count    <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !bus.PCSel && !reset)
            mem[wr_ptr] <= bus.imem_rsp_data;
    end
endmodule

// File: tb/tb_if_prefetch_unit.sv
// Directed table-driven bench for if_prefetch_unit: each row drives one cycle's inputs and
// checks the outputs seen before the following rising edge.
module tb_if_prefetch_unit;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    if_prefetch_unit_if bus ();

    if_prefetch_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic        rst;
        logic        sel;
        logic [31:0] alu;
        logic        rdy;
        logic        rsp;
        logic [31:0] rdata;
        logic        ir;
        logic        e_rv;
        logic [31:0] e_addr;
        logic        e_iv;
        logic [31:0] e_inst;
        logic [31:0] e_pc;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic rst, input logic sel, input logic [31:0] alu,
                                input logic rdy, input logic rsp, input logic [31:0] rdata,
                                input logic ir, input logic e_rv, input logic [31:0] e_addr,
                                input logic e_iv, input logic [31:0] e_inst, input logic [31:0] e_pc);
        vec_t v;
        v.rst = rst; v.sel = sel; v.alu = alu; v.rdy = rdy; v.rsp = rsp; v.rdata = rdata;
        v.ir = ir; v.e_rv = e_rv; v.e_addr = e_addr; v.e_iv = e_iv; v.e_inst = e_inst; v.e_pc = e_pc;
        return v;
    endfunction

    task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    task automatic step(input int row, input vec_t v);
        @(negedge clk);
        reset              = v.rst;
        bus.PCSel          = v.sel;
        bus.from_alu       = v.alu;
        bus.imem_req_ready = v.rdy;
        bus.imem_rsp_valid = v.rsp;
        bus.imem_rsp_data  = v.rdata;
        bus.inst_ready     = v.ir;
        #1;
        chk("req_valid", row, 32'(bus.imem_req_valid), 32'(v.e_rv));
        if (v.e_rv) chk("req_addr", row, bus.imem_req_addr, v.e_addr);
        chk("inst_valid", row, 32'(bus.inst_valid), 32'(v.e_iv));
        if (v.e_iv) chk("inst", row, bus.inst, v.e_inst);
        if (!v.rst) begin
            chk("pc_out", row, bus.pc_out, v.e_pc);
            chk("pc_plus_4", row, bus.pc_plus_4, v.e_pc + 32'd4);
        end
    endtask

    initial begin
        bus.PCSel = 1'b0; bus.from_alu = '0; bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = '0; bus.inst_ready = 1'b0;

        // reset, then streaming with 1-cycle responses
        tbl.push_back(mk(1,0,0,      0,0,0,            0, 0,0,          0,0,            0));
        tbl.push_back(mk(1,0,0,      0,0,0,            0, 0,0,          0,0,            0));
        tbl.push_back(mk(0,0,0,      1,0,0,            1, 1,32'h0,      0,0,            32'h0));
        tbl.push_back(mk(0,0,0,      1,1,32'hD000_0000,1, 1,32'h4,      0,0,            32'h0));
        tbl.push_back(mk(0,0,0,      1,1,32'hD000_0004,1, 1,32'h8,      1,32'hD000_0000,32'h0));
        tbl.push_back(mk(0,0,0,      1,1,32'hD000_0008,1, 1,32'hC,      1,32'hD000_0004,32'h4));
        tbl.push_back(mk(0,0,0,      0,1,32'hD000_000C,1, 1,32'h10,     1,32'hD000_0008,32'h8));
        tbl.push_back(mk(0,0,0,      0,0,0,            1, 1,32'h10,     1,32'hD000_000C,32'hC));
        tbl.push_back(mk(0,0,0,      0,0,0,            1, 1,32'h10,     0,0,            32'h10));
        // decode stalled: queue fills to 4, then drains
        tbl.push_back(mk(0,0,0,      1,0,0,            0, 1,32'h10,     0,0,            32'h10));
        tbl.push_back(mk(0,0,0,      1,1,32'hD000_0010,0, 1,32'h14,     0,0,            32'h10));
        tbl.push_back(mk(0,0,0,      1,1,32'hD000_0014,0, 1,32'h18,     1,32'hD000_0010,32'h10));
        tbl.push_back(mk(0,0,0,      1,1,32'hD000_0018,0, 1,32'h1C,     1,32'hD000_0010,32'h10));
        tbl.push_back(mk(0,0,0,      1,1,32'hD000_001C,0, 0,0,          1,32'hD000_0010,32'h10));
        tbl.push_back(mk(0,0,0,      1,0,0,            0, 0,0,          1,32'hD000_0010,32'h10));
        tbl.push_back(mk(0,0,0,      1,0,0,            1, 0,0,          1,32'hD000_0010,32'h10));
        tbl.push_back(mk(0,0,0,      1,0,0,            1, 1,32'h20,     1,32'hD000_0014,32'h14));
        tbl.push_back(mk(0,0,0,      0,1,32'hD000_0020,1, 1,32'h24,     1,32'hD000_0018,32'h18));
        tbl.push_back(mk(0,0,0,      0,0,0,            1, 1,32'h24,     1,32'hD000_001C,32'h1C));
        tbl.push_back(mk(0,0,0,      0,0,0,            1, 1,32'h24,     1,32'hD000_0020,32'h20));
        tbl.push_back(mk(0,0,0,      0,0,0,            1, 1,32'h24,     0,0,            32'h24));
        // two in flight, redirect to 0x100 drops both
        tbl.push_back(mk(0,0,0,      1,0,0,            1, 1,32'h24,     0,0,            32'h24));
        tbl.push_back(mk(0,0,0,      1,0,0,            1, 1,32'h28,     0,0,            32'h24));
        tbl.push_back(mk(0,1,32'h100,1,0,0,            1, 0,0,          0,0,            32'h24));
        tbl.push_back(mk(0,0,0,      0,1,32'hBAD0_0024,1, 1,32'h100,    0,0,            32'h100));
        tbl.push_back(mk(0,0,0,      1,1,32'hBAD0_0028,1, 1,32'h100,    0,0,            32'h100));
        tbl.push_back(mk(0,0,0,      0,1,32'hD000_0100,1, 1,32'h104,    0,0,            32'h100));
        tbl.push_back(mk(0,0,0,      0,0,0,            1, 1,32'h104,    1,32'hD000_0100,32'h100));
        tbl.push_back(mk(0,0,0,      0,0,0,            1, 1,32'h104,    0,0,            32'h104));
        // memory not ready for 5 cycles at the top of the address space, then wrap
        tbl.push_back(mk(0,1,32'hFFFF_FFFC,0,0,0,      1, 0,0,          0,0,            32'h104));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(0,0,0,  0,0,0,            1, 1,32'hFFFF_FFFC,0,0,          32'hFFFF_FFFC));
        tbl.push_back(mk(0,0,0,      1,0,0,            1, 1,32'hFFFF_FFFC,0,0,          32'hFFFF_FFFC));
        tbl.push_back(mk(0,0,0,      0,1,32'hCAFE_F00D,1, 1,32'h0,      0,0,            32'hFFFF_FFFC));
        tbl.push_back(mk(0,0,0,      0,0,0,            1, 1,32'h0,      1,32'hCAFE_F00D,32'hFFFF_FFFC));
        tbl.push_back(mk(0,0,0,      0,0,0,            1, 1,32'h0,      0,0,            32'h0));

        foreach (tbl[i]) step(i, tbl[i]);

        // reset mid-stream with two queued and two live responses outstanding
        step(100, mk(0,1,32'h40,0,0,0,            0, 0,0,       0,0,            32'h0));
        step(101, mk(0,0,0,     1,0,0,            0, 1,32'h40,  0,0,            32'h40));
        step(102, mk(0,0,0,     1,0,0,            0, 1,32'h44,  0,0,            32'h40));
        step(103, mk(0,0,0,     1,0,0,            0, 1,32'h48,  0,0,            32'h40));
        step(104, mk(0,0,0,     1,0,0,            0, 1,32'h4C,  0,0,            32'h40));
        step(105, mk(0,0,0,     1,1,32'hD000_0040,0, 0,0,       0,0,            32'h40));
        step(106, mk(0,0,0,     1,1,32'hD000_0044,0, 0,0,       1,32'hD000_0040,32'h40));
        step(107, mk(1,0,0,     0,0,0,            0, 0,0,       0,0,            32'h0));
        step(108, mk(0,0,0,     0,1,32'hD000_0048,1, 1,32'h0,   0,0,            32'h0));
        step(109, mk(0,0,0,     0,1,32'hD000_004C,1, 1,32'h0,   0,0,            32'h0));
        step(110, mk(0,0,0,     0,0,0,            1, 1,32'h0,   0,0,            32'h0));

`ifdef IF_MISALIGN_CHECK_EN
        step(200, mk(0,1,32'h102,0,0,0, 1, 0,0,       0,0, 32'h0));
        step(201, mk(0,0,0,      1,0,0, 1, 0,0,       0,0, 32'h102));
        chk("if_misalign_set", 201, 32'(bus.if_misalign), 32'd1);
        step(202, mk(0,0,0,      1,0,0, 1, 0,0,       0,0, 32'h102));
        step(203, mk(0,1,32'h200,1,0,0, 1, 0,0,       0,0, 32'h102));
        step(204, mk(0,0,0,      1,0,0, 1, 1,32'h200, 0,0, 32'h200));
        chk("if_misalign_clr", 204, 32'(bus.if_misalign), 32'd0);
`else
        // low address bits are cleared on redirect
        step(200, mk(0,1,32'h102,0,0,0, 1, 0,0,       0,0, 32'h0));
        step(201, mk(0,0,0,      0,0,0, 1, 1,32'h100, 0,0, 32'h100));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
